// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                             |
// | Description : Pipeline hazard controller. Merges stall requesters into a   |
// |               per-stage stall vector, defers branch flushes across stalls, |
// |               runs a debug halt/drain handshake and a stall watchdog.      |
// |               Optional perf counters enabled by PIPE_CTRL_PERF_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
   parameter int unsigned       STAGES      = 5,
   parameter int unsigned       NREQ        = 3,
   parameter logic [NREQ*8-1:0] REQ_DEPTH   = {8'd4, 8'd2, 8'd1},
   parameter int unsigned       FLUSH_DEPTH = 2,
   parameter int unsigned       WDOG_LIMIT  = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   stall_req_i,
   input  logic              flush_i,
   input  logic              halt_req_i,
   output logic [STAGES-1:0] stall_o,
   output logic [STAGES-1:0] flush_o,
   output logic              halt_ack_o,
   output logic              stall_timeout_o,
   output logic [31:0]       stall_cycles_o,
   output logic [31:0]       flush_count_o
);

   localparam int unsigned       c_drain_w    = (STAGES > 2) ? $clog2(STAGES) : 1;
   localparam logic [c_drain_w-1:0] c_drain_init = c_drain_w'(STAGES - 1);
   localparam logic [STAGES-1:0] c_flush_mask = STAGES'((64'd1 << FLUSH_DEPTH) - 64'd1);
   localparam logic [31:0]       c_wd_limit   = 32'(WDOG_LIMIT);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [c_drain_w-1:0] drain_cnt_q, drain_cnt_d;
   logic                 flush_pend_q, flush_pend_d;
   logic [31:0]          wd_cnt_q, wd_cnt_d;
   logic                 timeout_q, timeout_d;
   logic                 halt_ack_q, halt_ack_d;
   logic [STAGES-1:0]    req_stall;
   logic                 eff;

   // Each asserted requester freezes stages 0..REQ_DEPTH[i]; the widest prefix wins
   always_comb begin
      req_stall = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (stall_req_i[i]) begin
            for (int k = 0; k < int'(STAGES); k++) begin
               if (k <= int'({24'd0, REQ_DEPTH[i*8 +: 8]})) begin
                  req_stall[k] = 1'b1;
               end
            end
         end
      end
   end

   // Halt FSM, stall/flush outputs, flush deferral and watchdog next-state
   always_comb begin
      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      flush_pend_d = flush_pend_q;
      wd_cnt_d     = '0;
      timeout_d    = timeout_q;
      stall_o      = '0;
      flush_o      = '0;
      eff          = 1'b0;

      if (!rst) begin
         case (state_q)
            ST_RUN: begin
               stall_o = req_stall;
               if (halt_req_i) begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = c_drain_init;
               end
            end
            ST_DRAIN: begin
               // Only fetch is frozen so older instructions can retire
               stall_o = req_stall | STAGES'(1);
               if (!halt_req_i) begin
                  state_d = ST_RUN;
               end else if (!stall_o[STAGES-1]) begin
                  if (drain_cnt_q <= c_drain_w'(1)) begin
                     drain_cnt_d = '0;
                     state_d     = ST_HALTED;
                  end else begin
                     drain_cnt_d = drain_cnt_q - 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               stall_o = '1;
               if (!halt_req_i) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase

         // A flush only fires in RUN with its source stage moving; otherwise it waits
         eff     = (flush_i | flush_pend_q) & (state_q == ST_RUN) & ~stall_o[FLUSH_DEPTH];
         flush_o = eff ? c_flush_mask : '0;
         if (eff) begin
            flush_pend_d = 1'b0;
         end else if (flush_i) begin
            flush_pend_d = 1'b1;
         end

         if ((WDOG_LIMIT != 0) && (state_q == ST_RUN) && (|stall_o)) begin
            wd_cnt_d = (wd_cnt_q >= c_wd_limit) ? c_wd_limit : wd_cnt_q + 32'd1;
         end
         if ((WDOG_LIMIT != 0) && (wd_cnt_d == c_wd_limit)) begin
            timeout_d = 1'b1;
         end
      end

      halt_ack_d = (state_d == ST_HALTED);
   end

   // Control state registers, all cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         drain_cnt_q  <= '0;
         flush_pend_q <= 1'b0;
         wd_cnt_q     <= '0;
         timeout_q    <= 1'b0;
         halt_ack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         flush_pend_q <= flush_pend_d;
         wd_cnt_q     <= wd_cnt_d;
         timeout_q    <= timeout_d;
         halt_ack_q   <= halt_ack_d;
      end
   end

   assign halt_ack_o      = halt_ack_q;
   assign stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   // Wrapping perf counters: fetch-stall cycles and issued flushes
   always_comb begin
      stall_cycles_d = stall_cycles_q + {31'd0, stall_o[0]};
      flush_count_d  = flush_count_q + {31'd0, eff};
   end

   // Perf counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_count_o  = flush_count_q;
`else
   assign stall_cycles_o = '0;
   assign flush_count_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_hazard_ctrl                                          |
// | Description : Self-checking bench for pipe_hazard_ctrl (WDOG_LIMIT=8),     |
// |               directed scenarios plus randomized traffic vs a model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  stall_req;
   logic        flush;
   logic        halt;
   logic [4:0]  stall_o;
   logic [4:0]  flush_o;
   logic        halt_ack_o;
   logic        stall_timeout_o;
   logic [31:0] stall_cycles_o;
   logic [31:0] flush_count_o;

   int checks = 0;
   int errors = 0;

   // model: mode 0=run 1=drain 2=halted
   int          m_mode;
   int          m_drain;
   bit          m_pend;
   int          m_wd;
   bit          m_to;
   bit          m_ack;
   logic [31:0] m_sc;
   logic [31:0] m_fc;
   int          depth [3] = '{1, 2, 4};

   pipe_hazard_ctrl #(.WDOG_LIMIT(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_req_i     (stall_req),
      .flush_i         (flush),
      .halt_req_i      (halt),
      .stall_o         (stall_o),
      .flush_o         (flush_o),
      .halt_ack_o      (halt_ack_o),
      .stall_timeout_o (stall_timeout_o),
      .stall_cycles_o  (stall_cycles_o),
      .flush_count_o   (flush_count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] f_req(input logic [2:0] r);
      logic [4:0] m = '0;
      for (int i = 0; i < 3; i++)
         if (r[i]) m = m | 5'((1 << (depth[i] + 1)) - 1);
      return m;
   endfunction

   function automatic logic [4:0] f_stall();
      if (m_mode == 0) return f_req(stall_req);
      if (m_mode == 1) return f_req(stall_req) | 5'b00001;
      return 5'b11111;
   endfunction

   function automatic bit f_eff();
      logic [4:0] s = f_stall();
      return (m_mode == 0) && (flush || m_pend) && !s[2];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_drain = 0; m_pend = 0; m_wd = 0;
      m_to = 0; m_ack = 0; m_sc = '0; m_fc = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_stall"}, {27'd0, stall_o}, 32'd0);
      chk({tag, "_flush"}, {27'd0, flush_o}, 32'd0);
      chk({tag, "_ack"}, {31'd0, halt_ack_o}, 32'd0);
      chk({tag, "_tmo"}, {31'd0, stall_timeout_o}, 32'd0);
      chk({tag, "_scyc"}, stall_cycles_o, 32'd0);
      chk({tag, "_fcnt"}, flush_count_o, 32'd0);
   endtask

   // compare every output against the model at the falling edge
   task automatic sample();
      logic [4:0] s;
      @(negedge clk);
      s = f_stall();
      chk("stall", {27'd0, stall_o}, {27'd0, s});
      chk("flush", {27'd0, flush_o}, f_eff() ? 32'd3 : 32'd0);
      chk("ack", {31'd0, halt_ack_o}, {31'd0, m_ack});
      chk("tmo", {31'd0, stall_timeout_o}, {31'd0, m_to});
`ifdef PIPE_CTRL_PERF_EN
      chk("scyc", stall_cycles_o, m_sc);
      chk("fcnt", flush_count_o, m_fc);
`else
      chk("scyc", stall_cycles_o, 32'd0);
      chk("fcnt", flush_count_o, 32'd0);
`endif
   endtask

   // step the model with the current inputs, then cross the rising edge
   task automatic advance();
      logic [4:0] s = f_stall();
      bit e = f_eff();
      if (e) m_pend = 0;
      else if (flush) m_pend = 1;
      if (m_mode == 0 && s != 0) m_wd = (m_wd >= 8) ? 8 : m_wd + 1;
      else m_wd = 0;
      if (m_wd == 8) m_to = 1;
      m_sc = m_sc + {31'd0, s[0]};
      m_fc = m_fc + {31'd0, e};
      case (m_mode)
         0: if (halt) begin m_mode = 1; m_drain = 4; end
         1: if (!halt) m_mode = 0;
            else if (!s[4]) begin
               m_drain = m_drain - 1;
               if (m_drain == 0) m_mode = 2;
            end
         default: if (!halt) m_mode = 0;
      endcase
      m_ack = (m_mode == 2);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      sample();
      advance();
   endtask

   initial begin
      rst = 1'b1; stall_req = '0; flush = 1'b0; halt = 1'b0;
      model_reset();
      #2;
      chk_zero("rst_init");
      @(posedge clk); #1;
      rst = 1'b0;

      // stall encoding
      stall_req = 3'b010; sample(); chk("tp_stall_010", {27'd0, stall_o}, 32'h07); advance();
      stall_req = 3'b101; sample(); chk("tp_stall_101", {27'd0, stall_o}, 32'h1f); advance();
      stall_req = 3'b000; sample(); chk("tp_stall_000", {27'd0, stall_o}, 32'h00); advance();

      // flush deferred across a 3-cycle MEM stall
      stall_req = 3'b100; flush = 1'b1;
      sample(); chk("tp_flush_held", {27'd0, flush_o}, 32'd0); advance();
      flush = 1'b0;
      cyc(); cyc();
      stall_req = 3'b000;
      sample(); chk("tp_flush_release", {27'd0, flush_o}, 32'h03); advance();
      sample(); chk("tp_flush_once", {27'd0, flush_o}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
      chk("tp_flush_count", flush_count_o, 32'd1);
`endif
      advance();

      // full halt / drain / release
      halt = 1'b1;
      cyc();
      for (int i = 0; i < 4; i++) begin
         sample(); chk("tp_drain_stall", {27'd0, stall_o}, 32'h01); advance();
      end
      sample(); chk("tp_halt_stall", {27'd0, stall_o}, 32'h1f);
      chk("tp_halt_ack", {31'd0, halt_ack_o}, 32'd1); advance();
      halt = 1'b0;
      cyc();
      sample(); chk("tp_unhalt_stall", {27'd0, stall_o}, 32'd0);
      chk("tp_unhalt_ack", {31'd0, halt_ack_o}, 32'd0); advance();

      // aborted drain
      halt = 1'b1;
      cyc(); cyc(); cyc();
      halt = 1'b0;
      cyc();
      sample(); chk("tp_abort_ack", {31'd0, halt_ack_o}, 32'd0);
      chk("tp_abort_stall", {27'd0, stall_o}, 32'd0); advance();

      // watchdog
      stall_req = 3'b001;
      repeat (8) cyc();
      stall_req = 3'b000;
      sample(); chk("tp_wdog_set", {31'd0, stall_timeout_o}, 32'd1); advance();
      sample(); chk("tp_wdog_sticky", {31'd0, stall_timeout_o}, 32'd1); advance();

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         stall_req = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         flush     = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) halt = ~halt;
         cyc();
      end

      // async reset mid-HALTED with a flush pending
      stall_req = 3'b000; flush = 1'b0; halt = 1'b1;
      repeat (7) cyc();
      sample(); chk("tp_pre_rst_halted", {31'd0, halt_ack_o}, 32'd1); advance();
      flush = 1'b1; cyc();
      flush = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_zero("tp_async_rst");
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0; halt = 1'b0;
      sample(); chk("tp_rst_no_flush", {27'd0, flush_o}, 32'd0);
      chk("tp_rst_wdog_clear", {31'd0, stall_timeout_o}, 32'd0); advance();
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the RISC-V core. Successor to the fixed 5-bit stall encoder.
- Combines N stall requesters into a per-stage stall vector and registers/defers branch flushes across stalls.
- Adds a debug halt/drain handshake and a stall watchdog.
- Sits beside the pipeline. Drives the stall/flush inputs of the pc_reg, if_id, id_ex, ex_mem and mem_wb registers.

Parameters:
- STAGES, 5: number of pipeline stages. Bit 0 is PC/IF; bit STAGES-1 is the last stage.
- NREQ, 3: number of stall requesters.
- REQ_DEPTH, {8'd4,8'd2,8'd1}: packed NREQ×8. Entry i is the highest stage index frozen by requester i. Entry 0 is in the LSBs.
- FLUSH_DEPTH, 2: flush source stage index. Flush kills stages [FLUSH_DEPTH-1:0].
- WDOG_LIMIT, 1023: consecutive-stall cycle limit. 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall_req_i  in  NREQ  per-requester stall level.
- flush_i  in  1  branch mispredict/jump from stage FLUSH_DEPTH.
- halt_req_i  in  1  debug halt request (level).
- stall_o  out  STAGES  bit k=1 holds stage k.
- flush_o  out  STAGES  bit k=1 clears pipeline register into stage k.
- halt_ack_o  out  1  pipeline drained and frozen.
- stall_timeout_o  out  1  sticky watchdog flag.
- stall_cycles_o  out  32  perf counter (see Optional Feature).
- flush_count_o  out  32  perf counter (see Optional Feature).

Behaviour:
- Request mask:
  - mask_i = bits [REQ_DEPTH_i:0] set.
  - req_stall = OR of mask_i over all asserted stall_req_i.
  - The widest prefix therefore wins. Example: 5'b11111 for the MEM requester, 5'b00111 for ID.
- Halt FSM, registered state, reset to RUN:
  - RUN: stall_o = req_stall. If halt_req_i=1, go to DRAIN with drain_cnt := STAGES-1.
  - DRAIN: stall_o = req_stall | 1. Only fetch is frozen; older instructions retire.
    - drain_cnt decrements on each cycle where stall_o[STAGES-1]=0.
    - Reaching 0 goes to HALTED.
    - halt_req_i=0 in DRAIN returns to RUN immediately.
  - HALTED: stall_o = all ones; halt_ack_o=1 (registered, asserts on the cycle HALTED is entered). halt_req_i=0 returns to RUN; halt_ack_o drops the next cycle.
- Flush:
  - eff = (flush_i | flush_pend) & ~stall_o[FLUSH_DEPTH].
  - flush_o = eff ? bits [FLUSH_DEPTH-1:0] set : 0.
  - flush_pend is set at the edge where flush_i=1 and stall_o[FLUSH_DEPTH]=1. It is cleared at the edge where eff=1.
  - flush_i and flush_pend together produce a single flush.
  - A flush requested in DRAIN/HALTED is deferred until RUN.
  - flush_o and stall_o are independent. The pipeline registers give flush priority over stall on the same bit.
- Watchdog:
  - wd_cnt counts consecutive cycles with stall_o≠0 while in RUN. It clears on any cycle with stall_o=0 or state≠RUN, and saturates at WDOG_LIMIT.
  - On reaching WDOG_LIMIT, stall_timeout_o is set and held until rst.
- Reset:
  - All registers clear asynchronously: state=RUN, flush_pend=0, drain_cnt=0, wd_cnt=0.
  - stall_o, flush_o, halt_ack_o, stall_timeout_o and the counters are all 0 while rst=1, including combinational outputs.
  - Reset mid-DRAIN or mid-HALTED returns to RUN and drops any pending flush.
- Latency:
  - stall_o and flush_o are combinational from inputs and state (0-cycle).
  - halt_ack_o and stall_timeout_o are registered (1 cycle).

Optional Feature:
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles_o increments each cycle stall_o[0]=1.
  - flush_count_o increments each cycle eff=1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built. Ports remain present.

Test Plan:
- Defaults, stall_req_i=3'b010 → stall_o=5'b00111. stall_req_i=3'b101 → 5'b11111. stall_req_i=0 → 5'b00000.
- flush_i pulse while stall_req_i=3'b100 held 3 cycles → flush_o=0 during the stall. flush_o=5'b00011 on the first unstalled cycle only. flush_count_o=1 with PERF_EN.
- halt_req_i=1, no stalls → stall_o=5'b00001 for 4 cycles, then 5'b11111 with halt_ack_o=1. Drop halt_req_i → next cycle stall_o=0, halt_ack_o=0.
- halt_req_i asserted then dropped after 2 DRAIN cycles → back to RUN, halt_ack_o never asserted.
- WDOG_LIMIT=8, stall_req_i=3'b001 held 8 cycles → stall_timeout_o=1 and stays 1 after the request drops. Deassert rst cycle clears it.
- rst asserted asynchronously mid-HALTED with flush pending → all outputs 0 immediately. After release: RUN, no flush issued.
